// File: rtl/noc_pkg.sv
// Shared NoC definitions: port indices, default radix and a width helper.
package noc_pkg;

  localparam int unsigned RESOURCE = 0;
  localparam int unsigned NORTH    = 1;
  localparam int unsigned EAST     = 2;
  localparam int unsigned SOUTH    = 3;
  localparam int unsigned WEST     = 4;

  localparam int unsigned PORT_N_DEFAULT = 5;

  // Index width for n entries; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at N-1.
module rr_pick #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  logic         found;
  int unsigned  pos;
  logic [W-1:0] pos_w;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    pos_w  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      // Explicit wrap so N need not be a power of two.
      pos = int'(ptr) + off;
      if (pos >= N) begin
        pos = pos - N;
      end
      pos_w = W'(pos);
      if (!found && req[pos_w]) begin
        found         = 1'b1;
        idx           = pos_w;
        onehot[pos_w] = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/xy_out_port_arbiter.sv
// Per-output-port scheduler: round-robin with bounded burst hold, pops the
// winning input FIFO and issues a registered select / write strobe one cycle later.
module xy_out_port_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned PORT_N    = PORT_N_DEFAULT,
  parameter int unsigned MAX_BURST = 2,
  parameter int unsigned SEL_W     = clog2(PORT_N)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [PORT_N-1:0] req_i,
  input  logic              nxt_fifo_full_i,
  output logic [PORT_N-1:0] rd_en_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              wr_en_o,
  output logic              grant_vld_o
);

  localparam logic [3:0]       BurstMax = 4'(MAX_BURST - 1);
  localparam logic [SEL_W-1:0] LastIdx  = SEL_W'(PORT_N - 1);

  logic [SEL_W-1:0]  ptr_q, last_q, sel_q;
  logic [3:0]        burst_cnt_q;
  logic              hold_vld_q, wr_en_q;

  logic [PORT_N-1:0] pick_onehot, last_onehot, others;
  logic [SEL_W-1:0]  pick_idx, winner;
  logic              pick_any, hold_take, issue;

  rr_pick #(
    .N(PORT_N),
    .W(SEL_W)
  ) u_rr_pick (
    .req    (req_i),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    last_onehot = PORT_N'(1) << last_q;
    others      = req_i & ~last_onehot;
    // Stay on the last winner until its burst is used up, unless nobody else wants the port.
    hold_take   = hold_vld_q & req_i[last_q] & ((burst_cnt_q < BurstMax) | ~(|others));
    issue       = rst_ni & pick_any & ~nxt_fifo_full_i;
    winner      = hold_take ? last_q : pick_idx;
    rd_en_o     = '0;
    if (issue) begin
      rd_en_o = hold_take ? last_onehot : pick_onehot;
    end
    grant_vld_o = |rd_en_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      last_q      <= '0;
      sel_q       <= '0;
      burst_cnt_q <= '0;
      hold_vld_q  <= 1'b0;
      wr_en_q     <= 1'b0;
    end else if (issue) begin
      sel_q      <= winner;
      wr_en_q    <= 1'b1;
      last_q     <= winner;
      hold_vld_q <= 1'b1;
      if (hold_vld_q && (winner == last_q)) begin
        burst_cnt_q <= (burst_cnt_q < BurstMax) ? burst_cnt_q + 4'd1 : burst_cnt_q;
      end else begin
        burst_cnt_q <= '0;
      end
      ptr_q <= (winner == LastIdx) ? '0 : winner + SEL_W'(1);
    end else begin
      wr_en_q <= 1'b0;
      if (!req_i[last_q]) begin
        hold_vld_q <= 1'b0;
      end
    end
  end

  assign sel_o   = sel_q;
  assign wr_en_o = wr_en_q;

endmodule

// File: tb/tb_xy_out_port_arbiter.sv
// Directed self-checking bench for xy_out_port_arbiter in three parameterisations.
module tb_xy_out_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // a: PORT_N=5, MAX_BURST=1   b: PORT_N=5, MAX_BURST=2   c: PORT_N=3, MAX_BURST=1
  logic [4:0] a_req, a_rd, b_req, b_rd;
  logic [2:0] c_req, c_rd;
  logic [2:0] a_sel, b_sel;
  logic [1:0] c_sel;
  logic       a_full, b_full, c_full;
  logic       a_wr, b_wr, c_wr, a_gv, b_gv, c_gv;

  xy_out_port_arbiter #(.PORT_N(5), .MAX_BURST(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .nxt_fifo_full_i(a_full),
    .rd_en_o(a_rd), .sel_o(a_sel), .wr_en_o(a_wr), .grant_vld_o(a_gv)
  );
  xy_out_port_arbiter #(.PORT_N(5), .MAX_BURST(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .nxt_fifo_full_i(b_full),
    .rd_en_o(b_rd), .sel_o(b_sel), .wr_en_o(b_wr), .grant_vld_o(b_gv)
  );
  xy_out_port_arbiter #(.PORT_N(3), .MAX_BURST(1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(c_req), .nxt_fifo_full_i(c_full),
    .rd_en_o(c_rd), .sel_o(c_sel), .wr_en_o(c_wr), .grant_vld_o(c_gv)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves time at posedge+1, ready to drive cycle 1.
  task automatic do_reset();
    rst_n  = 1'b0;
    a_req  = '0; b_req = '0; c_req = '0;
    a_full = 1'b0; b_full = 1'b0; c_full = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] fair_rd  [4] = '{5'b00010, 5'b00100, 5'b10000, 5'b00010};
    logic [2:0] fair_sel [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [4:0] burst_rd [6] = '{5'b00001, 5'b00001, 5'b00010, 5'b00010, 5'b00001, 5'b00001};
    logic [4:0] bp_rd    [7] = '{5'b00100, 5'b00100, 5'b0, 5'b0, 5'b0, 5'b00100, 5'b00100};
    logic       bp_wr    [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0] wrap_rd  [4] = '{3'b001, 3'b100, 3'b001, 3'b100};
    logic [1:0] wrap_sel [5] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd2};

    // Reset state
    do_reset();
    #4;
    chk("reset_rd", 32'(b_rd), 32'd0);
    chk("reset_wr", 32'(b_wr), 32'd0);
    chk("reset_sel", 32'(b_sel), 32'd0);
    chk("reset_gv", 32'(b_gv), 32'd0);

    // Fairness, MAX_BURST=1
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a_req = 5'b10110;
      #4;
      chk($sformatf("fair_rd[%0d]", k), 32'(a_rd), 32'(fair_rd[k]));
      chk($sformatf("fair_wr[%0d]", k), 32'(a_wr), (k == 0) ? 32'd0 : 32'd1);
      if (k > 0) chk($sformatf("fair_sel[%0d]", k), 32'(a_sel), 32'(fair_sel[k]));
      next_cycle();
    end
    a_req = '0;
    #4;
    chk("fair_rd_idle", 32'(a_rd), 32'd0);
    chk("fair_sel_last", 32'(a_sel), 32'd1);
    chk("fair_wr_last", 32'(a_wr), 32'd1);

    // Burst hold, MAX_BURST=2
    do_reset();
    for (int k = 0; k < 6; k++) begin
      b_req = 5'b00011;
      #4;
      chk($sformatf("burst_rd[%0d]", k), 32'(b_rd), 32'(burst_rd[k]));
      next_cycle();
    end

    // Lone requester: no bubble even after the burst counter saturates
    do_reset();
    for (int k = 0; k < 6; k++) begin
      b_req = 5'b00001;
      #4;
      chk($sformatf("lone_rd[%0d]", k), 32'(b_rd), 32'd1);
      chk($sformatf("lone_gv[%0d]", k), 32'(b_gv), 32'd1);
      if (k > 0) begin
        chk($sformatf("lone_wr[%0d]", k), 32'(b_wr), 32'd1);
        chk($sformatf("lone_sel[%0d]", k), 32'(b_sel), 32'd0);
      end
      next_cycle();
    end

    // Backpressure: full in cycles 3..5 (k = 2..4)
    do_reset();
    for (int k = 0; k < 7; k++) begin
      b_req  = 5'b00100;
      b_full = (k >= 2 && k <= 4);
      #4;
      chk($sformatf("bp_rd[%0d]", k), 32'(b_rd), 32'(bp_rd[k]));
      chk($sformatf("bp_wr[%0d]", k), 32'(b_wr), 32'(bp_wr[k]));
      if (bp_wr[k]) chk($sformatf("bp_sel[%0d]", k), 32'(b_sel), 32'd2);
      next_cycle();
    end
    b_full = 1'b0;

    // Asynchronous reset mid-stream: grants 0,0,1,1 then reset between edges
    do_reset();
    for (int k = 0; k < 4; k++) begin
      b_req = 5'b11111;
      next_cycle();
    end
    chk("mid_pre_wr", 32'(b_wr), 32'd1);
    chk("mid_pre_sel", 32'(b_sel), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rd", 32'(b_rd), 32'd0);
    chk("mid_wr", 32'(b_wr), 32'd0);
    chk("mid_sel", 32'(b_sel), 32'd0);
    chk("mid_gv", 32'(b_gv), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #4;
    chk("mid_first_rd", 32'(b_rd), 32'd1);
    next_cycle();
    b_req = '0;

    // Non-power-of-two wrap, PORT_N=3
    do_reset();
    for (int k = 0; k < 5; k++) begin
      c_req = (k < 4) ? 3'b101 : 3'b000;
      #4;
      if (k < 4) chk($sformatf("wrap_rd[%0d]", k), 32'(c_rd), 32'(wrap_rd[k]));
      if (k > 0) chk($sformatf("wrap_sel[%0d]", k), 32'(c_sel), 32'(wrap_sel[k]));
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xy_out_port_arbiter.md
Name: xy_out_port_arbiter

Overview:
- Per-output-port scheduler for the xy_switch: one instance per output port, PORT_N instances per switch.
- Arbitrates between input FIFOs whose head packet routes to this output.
- Pops the winning FIFO, drives the crossbar mux select, and produces the write enable to the next router.
- Round-robin fairness with a bounded burst hold; honours the next-hop FIFO full flag.

Parameters:
- PORT_N, 5, number of requesters (input ports); index 0 = RESOURCE.
- MAX_BURST, 2, max consecutive grants to one requester while another is requesting; range 1..15.
- SEL_W, $clog2(PORT_N), width of select index.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_i  input  PORT_N  bit i = input FIFO i non-empty and its head routes to this port.
- nxt_fifo_full_i  input  1  next-hop FIFO cannot accept a packet beyond one already in flight.
- rd_en_o  output  PORT_N  one-hot pop strobe to input FIFOs (combinational).
- sel_o  output  SEL_W  registered crossbar select; valid when wr_en_o=1.
- wr_en_o  output  1  registered write strobe to next hop.
- grant_vld_o  output  1  combinational, =|rd_en_o (debug/perf).

Behaviour:
- Reset, asynchronous on rst_ni low:
  - sel_o=0, wr_en_o=0.
  - ptr=0, last=0, burst_cnt=0, hold_vld=0.
  - rd_en_o=0 while in reset.
- Issue condition, each cycle: issue = |req_i & !nxt_fifo_full_i. When issue=0, rd_en_o=0.
- Winner selection when issue=1:
  - Hold case: hold_vld & req_i[last] & (burst_cnt < MAX_BURST-1 | req_i has no other bit set) -> winner=last.
  - Otherwise winner = first set bit of req_i scanning from ptr upward, wrapping PORT_N-1 -> 0.
  - rd_en_o = onehot(winner), same cycle.
- Register update on issue:
  - sel_o <= winner; wr_en_o <= 1; last <= winner; hold_vld <= 1.
  - winner==last & hold_vld -> burst_cnt <= burst_cnt+1, saturating at MAX_BURST-1 while alone.
  - Else burst_cnt <= 0.
  - ptr <= (winner+1) mod PORT_N; modulo computed explicitly, PORT_N need not be a power of two.
- Register update on no issue:
  - wr_en_o <= 0; sel_o holds.
  - hold_vld <= 0 if !req_i[last]; burst_cnt unchanged.
- Latency: FIFO read data is registered, so the packet appears at the FIFO output the cycle after rd_en_o. wr_en_o and sel_o are aligned to that cycle.
- Throughput: one packet per cycle sustained.
- Full handling:
  - nxt_fifo_full_i high -> no pop that cycle.
  - The packet already popped still completes (wr_en_o=1 next cycle). The downstream FIFO asserts full with one free slot to absorb it.
- MAX_BURST=1: pure round-robin, hold never taken while others request.
- Single requester: granted every cycle with no bubble.
- Reset mid-transfer: in-flight wr_en_o is dropped. The popped packet is lost; this is accepted and the switch-level reset clears all FIFOs.
- req_i bits outside 0..PORT_N-1 do not exist. X on req_i during reset is ignored.

Decomposition:
- Shared package noc_pkg:
  - Port index constants: RESOURCE=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
  - Default PORT_N.
  - clog2 helper function.
- Sub-module rr_pick (combinational): inputs req, ptr; outputs onehot, idx, any. Reusable by other arbiters in the NoC.

Test Plan:
- Reset: assert rst_ni=0 mid-stream with req_i=5'b11111 -> outputs go to 0 immediately, without waiting for a clock edge. After release, first winner is 0 (ptr=0).
- Fairness, PORT_N=5, MAX_BURST=1: req_i=5'b10110 constant, nxt_full=0 -> rd_en_o sequence 00010, 00100, 10000, 00010. wr_en_o=1 each cycle from cycle 2, with sel_o = 1, 2, 4, 1.
- Burst, MAX_BURST=2: req_i=5'b00011 from reset -> grants 0, 0, 1, 1, 0, 0.
- Burst with lone requester: req_i=5'b00001 only -> grant 0 every cycle, no bubble.
- Backpressure: req_i=5'b00100, nxt_full=1 for cycles 3–5 -> rd_en_o=0 in cycles 3–5. wr_en_o is 1 in cycle 3 (in-flight packet), 0 in cycles 4–6, and resumes at cycle 7.
- Wrap/non-pow2, PORT_N=3: req_i=3'b101 -> grants 0, 2, 0, 2. Pointer wraps from 2 to 0 and never selects index 3.
